// File: rtl/synthesijer_div_pkg.sv
// Shared types and constants for the synthesijer 32-bit divider issue stage.
package synthesijer_div_pkg;

    localparam int unsigned DIV_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ZERO  = 2'd3
    } div_issue_state_t;

    typedef struct packed {
        logic [DIV_DEFAULT_WIDTH-1:0] a;
        logic [DIV_DEFAULT_WIDTH-1:0] b;
    } div_operand_t;

endpackage

// File: rtl/synthesijer_div_fifo.sv
// Show-ahead operand FIFO: head is always the oldest entry while not empty.
module synthesijer_div_fifo
    import synthesijer_div_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * DIV_DEFAULT_WIDTH,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/synthesijer_div32_issue.sv
// Issue stage for the iterative divider: operand FIFO, one-at-a-time issue, held result slot.
// Optional zero-divisor bypass: define SYNTHESIJER_DIV_ZERO_CHECK_EN.
module synthesijer_div32_issue
    import synthesijer_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_nd,
    input  logic [WIDTH-1:0] div_quantient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_valid,
    output logic [WIDTH-1:0] m_quantient,
    output logic [WIDTH-1:0] m_remainder,
    output logic             m_divzero,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    // Async assert, sync deassert of the internal reset.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    logic [2*WIDTH-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ADDR_W:0]    fifo_count;
    logic               fifo_pop;
    logic               fifo_push;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;

    assign s_ready   = rst_n_int & ~fifo_full;
    assign fifo_push = s_valid & s_ready;
    assign head_a    = fifo_head[2*WIDTH-1:WIDTH];
    assign head_b    = fifo_head[WIDTH-1:0];

    synthesijer_div_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (rst_n_int),
        .push      (fifo_push),
        .push_data ({s_a, s_b}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    div_issue_state_t state_q;
    div_issue_state_t state_d;
    logic [WIDTH-1:0] div_a_d;
    logic [WIDTH-1:0] div_b_d;
    logic             div_nd_d;
    logic [WIDTH-1:0] m_quantient_d;
    logic [WIDTH-1:0] m_remainder_d;
    logic             m_valid_d;
    logic             slot_free;
`ifdef SYNTHESIJER_DIV_ZERO_CHECK_EN
    logic             m_divzero_d;
`endif

    assign slot_free = ~m_valid | m_ready;
    assign busy      = (state_q != IDLE) | (fifo_count != '0) | m_valid;

    // Next state, issue and result-slot update.
    always_comb begin
        state_d       = state_q;
        fifo_pop      = 1'b0;
        div_a_d       = div_a;
        div_b_d       = div_b;
        div_nd_d      = 1'b0;
        m_quantient_d = m_quantient;
        m_remainder_d = m_remainder;
        m_valid_d     = m_valid & ~m_ready;
`ifdef SYNTHESIJER_DIV_ZERO_CHECK_EN
        m_divzero_d   = m_divzero;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop = 1'b1;
                    div_a_d  = head_a;
                    div_b_d  = head_b;
`ifdef SYNTHESIJER_DIV_ZERO_CHECK_EN
                    if (head_b == '0) begin
                        state_d = ZERO;
                    end else begin
                        state_d  = ISSUE;
                        div_nd_d = 1'b1;
                    end
`else
                    state_d  = ISSUE;
                    div_nd_d = 1'b1;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (div_valid) begin
                    m_quantient_d = div_quantient;
                    m_remainder_d = div_remainder;
                    m_valid_d     = 1'b1;
`ifdef SYNTHESIJER_DIV_ZERO_CHECK_EN
                    m_divzero_d   = 1'b0;
`endif
                    state_d       = IDLE;
                end
            end
`ifdef SYNTHESIJER_DIV_ZERO_CHECK_EN
            ZERO: begin
                m_quantient_d = '1;
                m_remainder_d = div_a;
                m_divzero_d   = 1'b1;
                m_valid_d     = 1'b1;
                state_d       = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= IDLE;
            div_a       <= '0;
            div_b       <= '0;
            div_nd      <= 1'b0;
            m_quantient <= '0;
            m_remainder <= '0;
            m_valid     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_a       <= div_a_d;
            div_b       <= div_b_d;
            div_nd      <= div_nd_d;
            m_quantient <= m_quantient_d;
            m_remainder <= m_remainder_d;
            m_valid     <= m_valid_d;
        end
    end

`ifdef SYNTHESIJER_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            m_divzero <= 1'b0;
        end else begin
            m_divzero <= m_divzero_d;
        end
    end
`else
    assign m_divzero = 1'b0;
`endif

endmodule
